// File: rtl/fir_mac_ctrl.sv
// rtl/fir_mac_ctrl.sv - 17-tap FIR sequencer and multiply-accumulate stage
//
// Accepts one 14-bit sample at a time, pushes it into the external tap delay
// line, then accumulates the 17 tap outputs against a loadable Q2.14
// coefficient bank (one tap per cycle) and emits one 16-bit result per sample.
//
// Build option: FIR_MAC_SAT_EN - when defined the scaled result is clamped to
// [-32768, 32767]; when undefined y_out is acc[29:14] and wraps on overflow.
//
// Ports:
//   clk               clock, rising edge
//   rstn              asynchronous active-low reset
//   sample_valid      new input sample present
//   sample_in[13:0]   signed input sample
//   ready             high in IDLE; sample accepted on sample_valid && ready
//   sample_drop       one-cycle pulse after an edge where a sample was refused
//   shift_data_state  delay-line shift enable (registered)
//   head_flag         marks the first shift after reset
//   shift_data[13:0]  sample presented to the delay-line input
//   tap_0..tap_16     signed delay-line outputs, tap_0 newest
//   coef_we           coefficient write strobe (honoured only in IDLE)
//   coef_addr[4:0]    coefficient index, 0..16 valid
//   coef_wdata[15:0]  signed Q2.14 coefficient
//   y_out[15:0]       signed filter output, holds last value
//   y_valid           one-cycle pulse when y_out updates

module fir_mac_ctrl (
   input  logic        clk,
   input  logic        rstn,
   input  logic        sample_valid,
   input  logic [13:0] sample_in,
   output logic        ready,
   output logic        sample_drop,
   output logic        shift_data_state,
   output logic        head_flag,
   output logic [13:0] shift_data,
   input  logic [13:0] tap_0,
   input  logic [13:0] tap_1,
   input  logic [13:0] tap_2,
   input  logic [13:0] tap_3,
   input  logic [13:0] tap_4,
   input  logic [13:0] tap_5,
   input  logic [13:0] tap_6,
   input  logic [13:0] tap_7,
   input  logic [13:0] tap_8,
   input  logic [13:0] tap_9,
   input  logic [13:0] tap_10,
   input  logic [13:0] tap_11,
   input  logic [13:0] tap_12,
   input  logic [13:0] tap_13,
   input  logic [13:0] tap_14,
   input  logic [13:0] tap_15,
   input  logic [13:0] tap_16,
   input  logic        coef_we,
   input  logic [4:0]  coef_addr,
   input  logic [15:0] coef_wdata,
   output logic [15:0] y_out,
   output logic        y_valid
);

   localparam int NTAPS = 17;
   localparam logic [4:0] LAST_IDX = 5'd16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      MAC   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               accept;
   logic               mac_last;

   logic [15:0]        coef [NTAPS];
   logic [4:0]         idx;
   logic signed [34:0] acc;
   logic               head_seen;

   logic [13:0]        tap_sel;
   logic [15:0]        coef_sel;
   logic signed [29:0] tap_ext;
   logic signed [29:0] coef_ext;
   logic signed [29:0] prod;
   logic signed [20:0] acc_shr;
   logic [15:0]        y_scaled;
   logic               scale_unused;

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake decode
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      mac_last  = 1'b0;
      ready     = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (sample_valid) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            state_nxt = MAC;
         end
         MAC: begin
            if (idx == LAST_IDX) begin
               mac_last  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Tap select for the current MAC index
   always_comb begin
      tap_sel = 14'd0;
      case (idx)
         5'd0:    tap_sel = tap_0;
         5'd1:    tap_sel = tap_1;
         5'd2:    tap_sel = tap_2;
         5'd3:    tap_sel = tap_3;
         5'd4:    tap_sel = tap_4;
         5'd5:    tap_sel = tap_5;
         5'd6:    tap_sel = tap_6;
         5'd7:    tap_sel = tap_7;
         5'd8:    tap_sel = tap_8;
         5'd9:    tap_sel = tap_9;
         5'd10:   tap_sel = tap_10;
         5'd11:   tap_sel = tap_11;
         5'd12:   tap_sel = tap_12;
         5'd13:   tap_sel = tap_13;
         5'd14:   tap_sel = tap_14;
         5'd15:   tap_sel = tap_15;
         5'd16:   tap_sel = tap_16;
         default: tap_sel = 14'd0;
      endcase
   end

   always_comb begin
      coef_sel = 16'd0;
      if (idx <= LAST_IDX) begin
         coef_sel = coef[idx];
      end
   end

   // Both operands sign-extended to the 30-bit product width so the low
   // 30 bits of the multiply are the exact signed 14x16 product.
   assign tap_ext  = {{16{tap_sel[13]}}, tap_sel};
   assign coef_ext = {{14{coef_sel[15]}}, coef_sel};
   assign prod     = tap_ext * coef_ext;

   // Dropping the low 14 bits is an arithmetic shift right by 14 (floor).
   assign acc_shr = acc[34:14];

`ifdef FIR_MAC_SAT_EN
   always_comb begin
      y_scaled = acc_shr[15:0];
      if (acc_shr > 21'sd32767) begin
         y_scaled = 16'h7FFF;
      end else if (acc_shr < -21'sd32768) begin
         y_scaled = 16'h8000;
      end
   end
   assign scale_unused = ^acc[13:0];
`else
   assign y_scaled     = acc_shr[15:0];
   assign scale_unused = ^{acc_shr[20:16], acc[13:0]};
`endif

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shift_data_state <= 1'b0;
         head_flag        <= 1'b0;
         head_seen        <= 1'b0;
         shift_data       <= 14'd0;
         y_out            <= 16'd0;
         y_valid          <= 1'b0;
         sample_drop      <= 1'b0;
         acc              <= 35'sd0;
         idx              <= 5'd0;
         for (int i = 0; i < NTAPS; i++) begin
            coef[i] <= (i == 0) ? 16'h4000 : 16'h0000;
         end
      end else begin
         sample_drop <= sample_valid & ~ready;
         y_valid     <= 1'b0;

         case (state)
            IDLE: begin
               if (accept) begin
                  shift_data       <= sample_in;
                  shift_data_state <= 1'b1;
                  head_flag        <= ~head_seen;
                  head_seen        <= 1'b1;
               end
            end
            SHIFT: begin
               // Delay line captures shift_data on this edge.
               shift_data_state <= 1'b0;
               head_flag        <= 1'b0;
               acc              <= 35'sd0;
               idx              <= 5'd0;
            end
            MAC: begin
               acc <= acc + {{5{prod[29]}}, prod};
               if (!mac_last) begin
                  idx <= idx + 5'd1;
               end
            end
            DONE: begin
               y_out   <= y_scaled;
               y_valid <= 1'b1;
            end
            default: begin
            end
         endcase

         // Coefficients only change between samples so a MAC pass always
         // sees a consistent bank.
         if (coef_we && ready && (coef_addr <= LAST_IDX)) begin
            coef[coef_addr] <= coef_wdata;
         end
      end
   end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// tb/tb_fir_mac_ctrl.sv - self-checking bench for fir_mac_ctrl

module tb_fir_mac_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        sample_valid = 1'b0;
   logic [13:0] sample_in = 14'd0;
   logic        ready;
   logic        sample_drop;
   logic        shift_data_state;
   logic        head_flag;
   logic [13:0] shift_data;
   logic        coef_we = 1'b0;
   logic [4:0]  coef_addr = 5'd0;
   logic [15:0] coef_wdata = 16'd0;
   logic [15:0] y_out;
   logic        y_valid;

   logic [13:0] dl [17];

   int          checks = 0;
   int          errors = 0;
   int          yv_count = 0;
   logic [15:0] q [$];
   int          sw [17];
   int          sw_coef [17];

   always #5 clk = ~clk;

   fir_mac_ctrl dut (
      .clk              (clk),
      .rstn             (rstn),
      .sample_valid     (sample_valid),
      .sample_in        (sample_in),
      .ready            (ready),
      .sample_drop      (sample_drop),
      .shift_data_state (shift_data_state),
      .head_flag        (head_flag),
      .shift_data       (shift_data),
      .tap_0            (dl[0]),
      .tap_1            (dl[1]),
      .tap_2            (dl[2]),
      .tap_3            (dl[3]),
      .tap_4            (dl[4]),
      .tap_5            (dl[5]),
      .tap_6            (dl[6]),
      .tap_7            (dl[7]),
      .tap_8            (dl[8]),
      .tap_9            (dl[9]),
      .tap_10           (dl[10]),
      .tap_11           (dl[11]),
      .tap_12           (dl[12]),
      .tap_13           (dl[13]),
      .tap_14           (dl[14]),
      .tap_15           (dl[15]),
      .tap_16           (dl[16]),
      .coef_we          (coef_we),
      .coef_addr        (coef_addr),
      .coef_wdata       (coef_wdata),
      .y_out            (y_out),
      .y_valid          (y_valid)
   );

   // Delay-line model attached to the DUT
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 17; i++) dl[i] <= 14'd0;
      end else if (shift_data_state) begin
         for (int i = 16; i > 0; i--) dl[i] <= dl[i-1];
         dl[0] <= shift_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_out();
      longint acc;
      longint sh;
      acc = 0;
      for (int i = 0; i < 17; i++) acc += longint'(sw[i]) * longint'(sw_coef[i]);
      sh = acc >>> 14;
`ifdef FIR_MAC_SAT_EN
      if (sh > 32767) sh = 32767;
      else if (sh < -32768) sh = -32768;
`endif
      return sh[15:0];
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 17; i++) begin
         sw[i]      = 0;
         sw_coef[i] = (i == 0) ? 16384 : 0;
      end
   endfunction

   // Scoreboard consumer
   always @(negedge clk) begin
      if (rstn && y_valid) begin
         yv_count++;
         check("sb_nonempty", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) check("y_out", 32'(y_out), 32'(q.pop_front()));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      rstn = 1'b1;
   endtask

   // Returns at accept edge + 1
   task automatic send(input int s, input bit expect_out);
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in    = 14'(s);
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      if (expect_out) begin
         for (int i = 16; i > 0; i--) sw[i] = sw[i-1];
         sw[0] = s;
         q.push_back(model_out());
      end
   endtask

   task automatic write_coef(input int addr, input logic [15:0] val, input bit effective);
      @(negedge clk);
      coef_we    = 1'b1;
      coef_addr  = 5'(addr);
      coef_wdata = val;
      @(posedge clk);
      #1;
      coef_we = 1'b0;
      if (effective && addr <= 16) sw_coef[addr] = int'($signed(val));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      check("drain_timeout", 32'(q.size()), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int yv_snap;
      model_clear();

      // Reset values
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_shift", 32'(shift_data_state), 32'd0);
      check("rst_head", 32'(head_flag), 32'd0);
      check("rst_sdata", 32'(shift_data), 32'd0);
      check("rst_yout", 32'(y_out), 32'd0);
      check("rst_yvalid", 32'(y_valid), 32'd0);
      check("rst_drop", 32'(sample_drop), 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // Single sample with latency check
      send(100, 1'b1);
      check("e0_ready", 32'(ready), 32'd0);
      check("e0_shift", 32'(shift_data_state), 32'd1);
      check("e0_head", 32'(head_flag), 32'd1);
      check("e0_sdata", 32'(shift_data), 32'd100);
      for (int k = 1; k <= 19; k++) begin
         @(posedge clk);
         #1;
         check("lat_yvalid", 32'(y_valid), 32'(k == 19));
         if (k == 1) begin
            check("e1_shift", 32'(shift_data_state), 32'd0);
            check("e1_head", 32'(head_flag), 32'd0);
         end
         if (k == 19) check("e19_ready", 32'(ready), 32'd1);
      end
      wait_idle();
      check("pass_100", 32'(y_out), 32'd100);

      send(5, 1'b1);
      check("second_head", 32'(head_flag), 32'd0);
      wait_idle();

      // Single non-zero coefficient at tap 3
      do_reset();
      write_coef(0, 16'h0000, 1'b1);
      write_coef(3, 16'h2000, 1'b1);
      send(400, 1'b1); wait_idle();
      send(0, 1'b1);   wait_idle();
      send(0, 1'b1);   wait_idle();
      send(0, 1'b1);   wait_idle();
      check("tap3_out", 32'(y_out), 32'd200);

      // Coefficient writes while busy or out of range are ignored
      do_reset();
      send(300, 1'b1);
      repeat (5) @(posedge clk);
      write_coef(0, 16'h0000, 1'b0);
      wait_idle();
      write_coef(17, 16'h1234, 1'b0);
      send(7, 1'b1);
      wait_idle();
      check("busy_wr_ignored", 32'(y_out), 32'd7);

      // sample_valid held high for 45 edges
      do_reset();
      yv_snap = yv_count;
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in    = 14'd1234;
      for (int c = 0; c < 45; c++) begin
         @(posedge clk);
         #1;
         if (c % 20 == 0) begin
            for (int i = 16; i > 0; i--) sw[i] = sw[i-1];
            sw[0] = 1234;
            q.push_back(model_out());
         end
         check("held_accept", 32'(shift_data_state), 32'(c % 20 == 0));
         check("held_drop", 32'(sample_drop), 32'(c % 20 != 0));
      end
      sample_valid = 1'b0;
      check("held_yv_count", 32'(yv_count - yv_snap), 32'd2);
      wait_idle();

      // Reset mid-operation aborts the sample
      do_reset();
      send(555, 1'b0);
      yv_snap = yv_count;
      repeat (10) @(posedge clk);
      #1;
      rstn = 1'b0;
      model_clear();
      #1;
      check("abort_yout", 32'(y_out), 32'd0);
      check("abort_yvalid", 32'(y_valid), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("abort_no_yv", 32'(yv_count - yv_snap), 32'd0);
      check("abort_yout_hold", 32'(y_out), 32'd0);
      send(77, 1'b1);
      check("abort_head", 32'(head_flag), 32'd1);
      wait_idle();
      check("abort_recover", 32'(y_out), 32'd77);

      // Full-scale coefficients and taps: saturation / wrap
      do_reset();
      for (int i = 0; i < 17; i++) write_coef(i, 16'h7FFF, 1'b1);
      for (int i = 0; i < 17; i++) begin
         send(8191, 1'b1);
         wait_idle();
      end
`ifdef FIR_MAC_SAT_EN
      check("full_scale", 32'(y_out), 32'd32767);
`else
      check("full_scale", 32'(y_out), 32'd16341);
`endif
      for (int i = 0; i < 3; i++) begin
         send(-8192, 1'b1);
         wait_idle();
      end
      send(-3, 1'b1);
      wait_idle();

      check("sb_final_empty", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fir_mac_ctrl.md
# fir_mac_ctrl

Sequencer and multiply-accumulate stage for the 17-tap adaptive FIR. It accepts one input sample at a time and forwards it to the 14-bit tap delay line by pulsing `shift_data_state`. It then reads the 17 tap outputs back and accumulates them against a loadable coefficient bank, one tap per cycle. It emits one 16-bit filtered output per sample; it sits directly upstream of (drives) and downstream of (consumes) the delay line.

## Interface
- NTAPS, 17, number of taps/coefficients (fixed by delay line; not intended to change)
- clk  input  1  clock, rising edge
- rstn  input  1  reset, asynchronous, active-low
- sample_valid  input  1  new input sample present
- sample_in  input  14  signed input sample
- ready  output  1  high when state IDLE; sample accepted when sample_valid && ready
- sample_drop  output  1  one-cycle pulse: sample_valid high while not ready
- shift_data_state  output  1  delay-line shift enable, registered
- head_flag  output  1  high with shift_data_state for first sample after reset only
- shift_data  output  14  sample to delay line input, registered
- tap_0 … tap_16  input  14 each  signed delay-line outputs; tap_0 newest
- coef_we, coef_addr[4:0], coef_wdata[15:0]  input  coefficient write port, signed Q2.14
- y_out  output  16  signed filter output, holds last value
- y_valid  output  1  one-cycle pulse when y_out updates

## Operation
- States: IDLE, SHIFT, MAC, DONE.
- IDLE: on sample_valid, register shift_data<=sample_in, shift_data_state<=1, go SHIFT.
- SHIFT: shift_data_state high this cycle only, and the delay line captures on the next edge. On that edge: shift_data_state<=0, acc<=0, idx<=0, go MAC.
- MAC: each edge acc += tap[idx]*coef[idx] (signed 14x16 -> 30 bits, sign-extended into a 35-bit acc), idx++. After idx==16 is accumulated, go DONE.
- DONE: y_out<=scale(acc), y_valid<=1, go IDLE.
- scale: acc arithmetic-shifted right 14 (truncation toward -inf), then narrowed to 16 bits per Configuration.
- Coefficient write takes effect on the edge only when state IDLE and coef_addr<=16; otherwise ignored silently.
- Coefficients reset to coef[0]=16'h4000 (1.0) and all others 0, so the reset-state filter is a pure passthrough.
- head_flag: set with the first shift_data_state after reset, cleared with it, never again until reset.

## Timing
- Accept edge E0. shift_data_state is high during E0–E1. MAC accumulates at edges E2–E18. y_out/y_valid update at E19.
- ready is high again after E19; the next accept is at E20 earliest. Throughput is 1 sample per 20 cycles.
- sample_drop registered: pulse in the cycle after the offending edge. The sample is discarded, and the state is unaffected.
- Reset values: state IDLE, ready 1, shift_data_state 0, head_flag 0, shift_data 0, y_out 0, y_valid 0, sample_drop 0, acc 0, idx 0, coefficients as above.
- rstn low mid-operation aborts immediately. No y_valid for the aborted sample. The next sample after release asserts head_flag.
- sample_valid held high continuously: accepted at every IDLE edge, with sample_drop pulses for each busy-cycle edge.

## Configuration
- FIR_MAC_SAT_EN defined: shifted acc clamped to [-32768, 32767].
- FIR_MAC_SAT_EN undefined: y_out = acc[29:14], which wraps on overflow.
- All other behaviour is identical.

## Test plan
- Reset, single sample 100 with delay-line model attached -> y_out=100, y_valid at E19, head_flag high only with this shift.
- coef[0]=0, coef[3]=16'h2000; send 400, 0, 0, 0 -> fourth output = 200, earlier outputs 0.
- All coef=16'h7FFF, all taps 8191 -> y_out=32767 with FIR_MAC_SAT_EN, 16341 without.
- sample_valid held high 45 cycles -> samples accepted at E0, E20, E40. sample_drop pulses on every other edge. Exactly 2 y_valid pulses complete within the window.
- coef write during MAC (addr 0, value 0) -> ignored; current and next outputs unchanged versus model.
- rstn low at E10 for 2 cycles -> y_valid never pulses, y_out=0. Next sample re-asserts head_flag and produces a correct result.
